// File: rtl/fm_disc_pkg.sv
// Shared widths and helpers for the conjugate-product FM discriminator.
// Optional rounding stage is enabled by defining FM_DISC_ROUND_EN.
package fm_disc_pkg;

  function automatic int chw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One guard bit beyond IW+1 so (d-c) never wraps at full scale
  function automatic int sum_w(input int iw);
    return iw + 2;
  endfunction

  function automatic int prod_w(input int iw);
    return 2 * iw + 2;
  endfunction

  function automatic int res_w(input int iw);
    return 2 * iw + 2;
  endfunction

  function automatic logic signed [63:0] sat_shift(
    input logic signed [63:0] r,
    input int                 s,
    input int                 ow
  );
    logic signed [63:0] t;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    t  = r >>> s;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (t > hi)      return hi;
    else if (t < lo) return lo;
    else             return t;
  endfunction

endpackage

// File: rtl/fm_cmul3.sv
// Pipelined 3-multiplier complex multiply (a+jb)*(c+jd).
// Three ce-gated stages: k-sums, products, re/im combine.
module fm_cmul3
  import fm_disc_pkg::*;
#(
  parameter int IW = 16,
  parameter int TW = 1
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         clr,
  input  logic                         ce,
  input  logic                         i_valid,
  input  logic [TW-1:0]                i_tag,
  input  logic signed [IW-1:0]         i_a,
  input  logic signed [IW-1:0]         i_b,
  input  logic signed [IW-1:0]         i_c,
  input  logic signed [IW:0]           i_d,
  output logic                         o_valid,
  output logic [TW-1:0]                o_tag,
  output logic signed [prod_w(IW)-1:0] o_re,
  output logic signed [prod_w(IW)-1:0] o_im
);

  localparam int SW = sum_w(IW);
  localparam int PW = prod_w(IW);

  logic          r_v2, r_v3, r_v4;
  logic [TW-1:0] r_t2, r_t3, r_t4;
  logic signed [SW-1:0] r_a2, r_b2, r_c2;
  logic signed [SW-1:0] r_s1, r_s2, r_s3;
  logic signed [PW-1:0] r_k1, r_k2, r_k3;
  logic signed [PW-1:0] r_re, r_im;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
      r_v4 <= 1'b0;
      r_t2 <= '0;
      r_t3 <= '0;
      r_t4 <= '0;
      r_a2 <= '0;
      r_b2 <= '0;
      r_c2 <= '0;
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
      r_k1 <= '0;
      r_k2 <= '0;
      r_k3 <= '0;
      r_re <= '0;
      r_im <= '0;
    end else if (clr) begin
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
      r_v4 <= 1'b0;
    end else if (ce) begin
      r_v2 <= i_valid;
      r_t2 <= i_tag;
      r_a2 <= SW'(i_a);
      r_b2 <= SW'(i_b);
      r_c2 <= SW'(i_c);
      r_s1 <= SW'(i_a) + SW'(i_b);
      r_s2 <= SW'(i_d) - SW'(i_c);
      r_s3 <= SW'(i_c) + SW'(i_d);
      r_v3 <= r_v2;
      r_t3 <= r_t2;
      r_k1 <= PW'(r_c2) * PW'(r_s1);
      r_k2 <= PW'(r_a2) * PW'(r_s2);
      r_k3 <= PW'(r_b2) * PW'(r_s3);
      r_v4 <= r_v3;
      r_t4 <= r_t3;
      r_re <= r_k1 - r_k3;
      r_im <= r_k1 + r_k2;
    end
  end

  assign o_valid = r_v4;
  assign o_tag   = r_t4;
  assign o_re    = r_re;
  assign o_im    = r_im;

endmodule

// File: rtl/fm_disc_conj.sv
// Conjugate-product FM discriminator y = x[n]*conj(x[n-LAG]), NCH channels.
// Define FM_DISC_ROUND_EN for round-half-up output (one extra stage).
module fm_disc_conj
  import fm_disc_pkg::*;
#(
  parameter int IW      = 16,
  parameter int OW      = 16,
  parameter int LAG     = 1,
  parameter int NCH     = 1,
  parameter int GAIN_SH = 0
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    clr,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [IW-1:0]    s_i,
  input  logic signed [IW-1:0]    s_q,
  input  logic [chw(NCH)-1:0]     s_ch,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [OW-1:0]    m_i,
  output logic signed [OW-1:0]    m_q,
  output logic [chw(NCH)-1:0]     m_ch,
  output logic                    err_ch
);

  localparam int CHW = chw(NCH);
  localparam int RW  = res_w(IW);
  localparam int RW1 = RW + 1;
  localparam int DW  = IW + 1;
  localparam int S   = RW - OW - GAIN_SH;
  localparam int CW  = $clog2(LAG + 1);

  logic signed [IW-1:0] r_hi [NCH][LAG];
  logic signed [IW-1:0] r_hq [NCH][LAG];
  logic [CW-1:0]        r_cnt [NCH];

  logic                 r_v1;
  logic [CHW-1:0]       r_ch1;
  logic signed [IW-1:0] r_a1, r_b1, r_c1;
  logic signed [IW:0]   r_d1;
  logic                 r_err;

  logic                 r_mv;
  logic signed [OW-1:0] r_mi, r_mq;
  logic [CHW-1:0]       r_mch;

  logic                 w_ce, w_acc, w_bad, w_prime;
  logic [CHW-1:0]       w_ci;

  assign w_ce    = !r_mv | m_ready;
  assign s_ready = w_ce & !clr;
  assign w_acc   = s_valid & s_ready;
  assign w_bad   = 32'(s_ch) >= 32'(NCH);
  assign w_ci    = w_bad ? '0 : s_ch;
  assign w_prime = (r_cnt[w_ci] == CW'(LAG));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_v1  <= 1'b0;
      r_ch1 <= '0;
      r_a1  <= '0;
      r_b1  <= '0;
      r_c1  <= '0;
      r_d1  <= '0;
      r_err <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        r_cnt[c] <= '0;
        for (int k = 0; k < LAG; k++) begin
          r_hi[c][k] <= '0;
          r_hq[c][k] <= '0;
        end
      end
    end else if (clr) begin
      r_v1  <= 1'b0;
      r_err <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        r_cnt[c] <= '0;
        for (int k = 0; k < LAG; k++) begin
          r_hi[c][k] <= '0;
          r_hq[c][k] <= '0;
        end
      end
    end else begin
      r_err <= w_acc & w_bad;
      if (w_ce) begin
        r_v1  <= w_acc & ~w_bad & w_prime;
        r_ch1 <= s_ch;
        r_a1  <= s_i;
        r_b1  <= s_q;
        r_c1  <= r_hi[w_ci][LAG-1];
        // widen before negating so -(-2^(IW-1)) stays positive
        r_d1  <= -(DW'(r_hq[w_ci][LAG-1]));
        if (w_acc & ~w_bad) begin
          for (int k = LAG - 1; k > 0; k--) begin
            r_hi[w_ci][k] <= r_hi[w_ci][k-1];
            r_hq[w_ci][k] <= r_hq[w_ci][k-1];
          end
          r_hi[w_ci][0] <= s_i;
          r_hq[w_ci][0] <= s_q;
          if (!w_prime) r_cnt[w_ci] <= r_cnt[w_ci] + CW'(1);
        end
      end
    end
  end

  logic                 w_v4;
  logic [CHW-1:0]       w_ch4;
  logic signed [RW-1:0] w_re, w_im;

  fm_cmul3 #(
    .IW (IW),
    .TW (CHW)
  ) u_cmul (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clr     (clr),
    .ce      (w_ce),
    .i_valid (r_v1),
    .i_tag   (r_ch1),
    .i_a     (r_a1),
    .i_b     (r_b1),
    .i_c     (r_c1),
    .i_d     (r_d1),
    .o_valid (w_v4),
    .o_tag   (w_ch4),
    .o_re    (w_re),
    .o_im    (w_im)
  );

  logic               w_ov;
  logic [CHW-1:0]     w_och;
  logic signed [RW:0] w_ox, w_oy;

`ifdef FM_DISC_ROUND_EN
  localparam logic signed [RW:0] HALF = RW1'(1) <<< (S - 1);

  logic               r_v5;
  logic [CHW-1:0]     r_ch5;
  logic signed [RW:0] r_rx, r_ry;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_v5  <= 1'b0;
      r_ch5 <= '0;
      r_rx  <= '0;
      r_ry  <= '0;
    end else if (clr) begin
      r_v5 <= 1'b0;
    end else if (w_ce) begin
      r_v5  <= w_v4;
      r_ch5 <= w_ch4;
      r_rx  <= RW1'(w_re) + HALF;
      r_ry  <= RW1'(w_im) + HALF;
    end
  end

  assign w_ov  = r_v5;
  assign w_och = r_ch5;
  assign w_ox  = r_rx;
  assign w_oy  = r_ry;
`else
  assign w_ov  = w_v4;
  assign w_och = w_ch4;
  assign w_ox  = RW1'(w_re);
  assign w_oy  = RW1'(w_im);
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_mv  <= 1'b0;
      r_mi  <= '0;
      r_mq  <= '0;
      r_mch <= '0;
    end else if (clr) begin
      r_mv <= 1'b0;
    end else if (w_ce) begin
      r_mv  <= w_ov;
      r_mch <= w_och;
      r_mi  <= OW'(sat_shift(64'(w_ox), S, OW));
      r_mq  <= OW'(sat_shift(64'(w_oy), S, OW));
    end
  end

  assign m_valid = r_mv;
  assign m_i     = r_mi;
  assign m_q     = r_mq;
  assign m_ch    = r_mch;
  assign err_ch  = r_err;

endmodule

// File: tb/tb_fm_disc_conj.sv
// Bench for fm_disc_conj: default, GAIN_SH=3 (lockstep) and NCH=2/LAG=2.
// Expected values come from a vector table and a reference model.
module tb_fm_disc_conj;

`ifdef FM_DISC_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif
  localparam int LAT = RND ? 5 : 4;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;

  logic               clrA = 1'b0, sA_valid = 1'b0, mA_ready = 1'b1;
  logic signed [15:0] sA_i = '0, sA_q = '0;
  logic [0:0]         sA_ch = '0;
  logic               sA_ready, mA_valid, errA;
  logic signed [15:0] mA_i, mA_q;
  logic [0:0]         mA_ch;

  logic               gA_ready, gA_valid, gA_err;
  logic signed [15:0] gA_i, gA_q;
  logic [0:0]         gA_ch;

  logic               clrC = 1'b0, sC_valid = 1'b0, mC_ready = 1'b1;
  logic signed [15:0] sC_i = '0, sC_q = '0;
  logic [0:0]         sC_ch = '0;
  logic               sC_ready, mC_valid, errC;
  logic signed [15:0] mC_i, mC_q;
  logic [0:0]         mC_ch;

  always #5 aclk = ~aclk;

  fm_disc_conj u_a (
    .aclk(aclk), .aresetn(aresetn), .clr(clrA),
    .s_valid(sA_valid), .s_ready(sA_ready),
    .s_i(sA_i), .s_q(sA_q), .s_ch(sA_ch),
    .m_valid(mA_valid), .m_ready(mA_ready),
    .m_i(mA_i), .m_q(mA_q), .m_ch(mA_ch), .err_ch(errA)
  );

  fm_disc_conj #(.GAIN_SH(3)) u_g (
    .aclk(aclk), .aresetn(aresetn), .clr(clrA),
    .s_valid(sA_valid), .s_ready(gA_ready),
    .s_i(sA_i), .s_q(sA_q), .s_ch(sA_ch),
    .m_valid(gA_valid), .m_ready(mA_ready),
    .m_i(gA_i), .m_q(gA_q), .m_ch(gA_ch), .err_ch(gA_err)
  );

  fm_disc_conj #(.NCH(2), .LAG(2)) u_c (
    .aclk(aclk), .aresetn(aresetn), .clr(clrC),
    .s_valid(sC_valid), .s_ready(sC_ready),
    .s_i(sC_i), .s_q(sC_q), .s_ch(sC_ch),
    .m_valid(mC_valid), .m_ready(mC_ready),
    .m_i(mC_i), .m_q(mC_q), .m_ch(mC_ch), .err_ch(errC)
  );

  typedef struct {
    int i0, q0, i1, q1;
    int ei, eq, gi, gq;
  } vec_t;

  typedef struct {
    int ch;
    int ei, eq, gi, gq;
  } exp_t;

  exp_t   qA[$];
  exp_t   qC[$];
  int     checks = 0;
  int     errors = 0;
  int     nC = 0;
  bit     run = 1'b0;
  bit     use_model = 1'b1;
  bit     expErrA = 1'b0;
  longint hI[2][2][2];
  longint hQ[2][2][2];
  int     cnt[2][2];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int satsh(input longint v, input int s);
    longint t;
    t = v;
    if (RND) t = t + (longint'(1) <<< (s - 1));
    t = t >>> s;
    if (t > 32767) t = 32767;
    if (t < -32768) t = -32768;
    return int'(t);
  endfunction

  task automatic model_step(input int d, input int lag, input int i,
                            input int q, input int ch, output bit has,
                            output longint re, output longint im);
    has = 1'b0;
    re  = 0;
    im  = 0;
    if (cnt[d][ch] == lag) begin
      has = 1'b1;
      re  = longint'(i) * hI[d][ch][lag-1] + longint'(q) * hQ[d][ch][lag-1];
      im  = longint'(q) * hI[d][ch][lag-1] - longint'(i) * hQ[d][ch][lag-1];
    end
    for (int k = lag - 1; k > 0; k--) begin
      hI[d][ch][k] = hI[d][ch][k-1];
      hQ[d][ch][k] = hQ[d][ch][k-1];
    end
    hI[d][ch][0] = i;
    hQ[d][ch][0] = q;
    if (cnt[d][ch] < lag) cnt[d][ch]++;
  endtask

  task automatic model_clear(input int d);
    for (int c = 0; c < 2; c++) begin
      cnt[d][c] = 0;
      for (int k = 0; k < 2; k++) begin
        hI[d][c][k] = 0;
        hQ[d][c][k] = 0;
      end
    end
  endtask

  // Handshakes are stable at the falling edge; the transfer happens next rise
  always @(negedge aclk) begin : mon
    exp_t   e;
    bit     has;
    longint re, im;
    if (run) begin
      if (mA_valid && mA_ready) begin
        if (qA.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL A_spurious: got output %0d/%0d, expected none",
                   mA_i, mA_q);
        end else begin
          e = qA.pop_front();
          chk("A_i", mA_i, e.ei);
          chk("A_q", mA_q, e.eq);
          chk("A_ch", mA_ch, e.ch);
          chk("G_valid", gA_valid, 1);
          chk("G_i", gA_i, e.gi);
          chk("G_q", gA_q, e.gq);
          chk("G_ch", gA_ch, e.ch);
        end
      end
      chk("A_err", errA, expErrA);
      chk("G_err", gA_err, expErrA);
      expErrA = 1'b0;
      if (sA_valid && sA_ready) begin
        chk("G_ready", gA_ready, 1);
        if (sA_ch != 0) expErrA = 1'b1;
        else if (use_model) begin
          model_step(0, 1, sA_i, sA_q, 0, has, re, im);
          if (has)
            qA.push_back('{0, satsh(re, 18), satsh(im, 18),
                           satsh(re, 15), satsh(im, 15)});
        end
      end
      if (clrA) begin
        model_clear(0);
        qA.delete();
      end

      if (mC_valid && mC_ready) begin
        nC++;
        if (qC.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL C_spurious: got output %0d/%0d, expected none",
                   mC_i, mC_q);
        end else begin
          e = qC.pop_front();
          chk("C_i", mC_i, e.ei);
          chk("C_q", mC_q, e.eq);
          chk("C_ch", mC_ch, e.ch);
        end
      end
      chk("C_err", errC, 0);
      if (sC_valid && sC_ready) begin
        model_step(1, 2, sC_i, sC_q, sC_ch, has, re, im);
        if (has)
          qC.push_back('{int'(sC_ch), satsh(re, 18), satsh(im, 18), 0, 0});
      end
      if (clrC) begin
        model_clear(1);
        qC.delete();
      end
    end
  end

  task automatic sendA(input int i, input int q, input int ch);
    int n;
    n        = 0;
    sA_valid = 1'b1;
    sA_i     = 16'(i);
    sA_q     = 16'(q);
    sA_ch    = 1'(ch);
    @(negedge aclk);
    while (!sA_ready && n < 200) begin
      @(negedge aclk);
      n++;
    end
    if (!sA_ready) begin
      checks++;
      errors++;
      $display("FAIL sendA_timeout: got s_ready=0, expected 1 within 200");
    end
    @(posedge aclk);
    #1;
    sA_valid = 1'b0;
  endtask

  task automatic sendC(input int i, input int q, input int ch);
    int n;
    n        = 0;
    sC_valid = 1'b1;
    sC_i     = 16'(i);
    sC_q     = 16'(q);
    sC_ch    = 1'(ch);
    @(negedge aclk);
    while (!sC_ready && n < 200) begin
      @(negedge aclk);
      n++;
    end
    if (!sC_ready) begin
      checks++;
      errors++;
      $display("FAIL sendC_timeout: got s_ready=0, expected 1 within 200");
    end
    @(posedge aclk);
    #1;
    sC_valid = 1'b0;
  endtask

  task automatic waitA(input int max);
    int n;
    n = 0;
    while ((qA.size() != 0 || mA_valid) && n < max) begin
      @(posedge aclk);
      #1;
      n++;
    end
    chk("A_drain", qA.size(), 0);
  endtask

  task automatic waitC(input int max);
    int n;
    n = 0;
    while ((qC.size() != 0 || mC_valid) && n < max) begin
      @(posedge aclk);
      #1;
      n++;
    end
    chk("C_drain", qC.size(), 0);
  endtask

  task automatic pulse_clrA();
    clrA = 1'b1;
    @(posedge aclk);
    #1;
    clrA = 1'b0;
  endtask

  task automatic pulse_clrC();
    clrC = 1'b1;
    @(posedge aclk);
    #1;
    clrC = 1'b0;
  endtask

  initial begin
    vec_t tbl[8];
    int   lat;

    tbl[0] = '{16384, 0, 16384, 0, 1024, 0, 8192, 0};
    tbl[1] = '{16384, 0, 0, 16384, 0, 1024, 0, 8192};
    tbl[2] = '{16384, 0, 0, -16384, 0, -1024, 0, -8192};
    tbl[3] = '{-32768, -32768, -32768, -32768, 8192, 0, 32767, 0};
    tbl[4] = '{32767, 0, -32768, 0, -4096, 0, -32767, 0};
    tbl[5] = '{100, 0, -1, 0, RND ? 0 : -1, 0, RND ? 0 : -1, 0};
    tbl[6] = '{1000, 2000, 3000, -4000, RND ? -19 : -20, RND ? -38 : -39,
               -153, RND ? -305 : -306};
    tbl[7] = '{32767, 32767, 32767, -32768, RND ? 0 : -1, -8192,
               -1, -32768};
    model_clear(0);
    model_clear(1);

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_m_valid", mA_valid, 0);
    chk("rst_m_i", mA_i, 0);
    chk("rst_m_q", mA_q, 0);
    chk("rst_m_ch", mA_ch, 0);
    chk("rst_err_ch", errA, 0);
    chk("rst_C_m_valid", mC_valid, 0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    run     = 1'b1;
    @(posedge aclk);
    #1;

    use_model = 1'b0;
    for (int k = 0; k < 8; k++) begin
      pulse_clrA();
      qA.push_back('{0, tbl[k].ei, tbl[k].eq, tbl[k].gi, tbl[k].gq});
      sendA(tbl[k].i0, tbl[k].q0, 0);
      sendA(tbl[k].i1, tbl[k].q1, 0);
      waitA(40);
    end
    use_model = 1'b1;

    pulse_clrA();
    sendA(16384, 0, 0);
    sendA(16384, 0, 0);
    lat = 0;
    for (int n = 1; n <= 10 && lat == 0; n++) begin
      @(posedge aclk);
      #1;
      if (mA_valid) lat = n;
    end
    chk("latency", lat, LAT);
    waitA(40);

    pulse_clrA();
    sendA(16384, 0, 0);
    sendA(999, -999, 1);
    chk("err_pulse", errA, 1);
    sendA(16384, 0, 0);
    waitA(40);

    pulse_clrA();
    fork
      begin
        for (int k = 0; k < 30; k++) sendA($urandom, $urandom, 0);
      end
      begin
        repeat (8) @(posedge aclk);
        #1;
        mA_ready = 1'b0;
        repeat (10) @(posedge aclk);
        #1;
        chk("bp_s_ready", sA_ready, 0);
        chk("bp_m_valid", mA_valid, 1);
        mA_ready = 1'b1;
      end
    join
    waitA(100);

    pulse_clrA();
    sendA(100, 200, 0);
    sendA(300, -400, 0);
    sendA(-500, 600, 0);
    sA_valid = 1'b1;
    sA_i     = 16'sd1234;
    sA_q     = '0;
    clrA     = 1'b1;
    @(negedge aclk);
    chk("clr_s_ready", sA_ready, 0);
    @(posedge aclk);
    #1;
    chk("clr_m_valid", mA_valid, 0);
    clrA     = 1'b0;
    sA_valid = 1'b0;
    sendA(16384, 0, 0);
    repeat (8) @(posedge aclk);
    #1;
    chk("reprime_m_valid", mA_valid, 0);
    sendA(0, 16384, 0);
    waitA(40);

    pulse_clrC();
    nC = 0;
    for (int k = 0; k < 12; k++) sendC($urandom, $urandom, k % 2);
    waitC(40);
    chk("C_outputs", nC, 8);

    repeat (2) @(posedge aclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
